// File: rtl/uart_line_loader.sv
// uart_line_loader: parses the UART header and packed-BCD lines into a valid/ready line stream
module uart_line_loader #(
  parameter int MAX_BYTES = 50,
  parameter int TIMEOUT   = 10_000_000
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_par_ok,
  input  logic                   err_clr,
  output logic                   hdr_valid,
  output logic [7:0]             hdr_len,
  output logic [11:0]            hdr_lines,
  output logic [3:0]             hdr_digits,
  output logic [8*MAX_BYTES-1:0] line_data,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic                   last_line,
  output logic                   err,
  output logic [1:0]             err_code
);
  localparam int W  = 8*MAX_BYTES;
  localparam int TW = $clog2(TIMEOUT+1);
  typedef enum logic [2:0] {SYNC, HDR, LOAD, HOLD, ERR} state_t;
  state_t          state_q, state_d, cur_st;
  logic [1:0]      hcnt_q, hcnt_d;
  logic [7:0]      hb1_q, hb1_d, hb2_q, hb2_d;
  logic [7:0]      len_q, len_d;
  logic [11:0]     lines_q, lines_d;
  logic [3:0]      dig_q, dig_d;
  logic            hv_q, hv_d;
  logic [W-1:0]    data_q, data_d, cur_data;
  logic [7:0]      cnt_q, cnt_d, cur_cnt;
  logic [11:0]     left_q, left_d, cur_left;
  logic            last_q, last_d, err_q, err_d;
  logic [1:0]      code_q, code_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            xfer, tmo, hdr_ok, bad_byte;
  logic [11:0]     nnn;
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= SYNC;
      hcnt_q  <= '0;
      hb1_q   <= '0;
      hb2_q   <= '0;
      len_q   <= '0;
      lines_q <= '0;
      dig_q   <= '0;
      hv_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      hb1_q   <= hb1_d;
      hb2_q   <= hb2_d;
      len_q   <= len_d;
      lines_q <= lines_d;
      dig_q   <= dig_d;
      hv_q    <= hv_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      last_q  <= last_d;
      err_q   <= err_d;
      code_q  <= code_d;
      tmr_q   <= tmr_d;
    end
  end
  always_comb begin
    xfer     = state_q == HOLD && line_ready;
    nnn      = {hb2_q, rx_data[7:4]};
    hdr_ok   = hb1_q != 8'd0 && 32'(hb1_q) <= MAX_BYTES && nnn != 12'd0 &&
               rx_data[3:0] != 4'd0 && {5'd0, rx_data[3:0]} <= {hb1_q, 1'b0};
    bad_byte = !rx_par_ok || rx_data[7:4] > 4'd9 || rx_data[3:0] > 4'd9;
    // a transfer hands this cycle's byte to the state that follows HOLD
    cur_st   = xfer ? (last_q ? SYNC : LOAD) : state_q;
    cur_data = xfer ? '0 : data_q;
    cur_cnt  = xfer ? 8'd0 : cnt_q;
    cur_left = xfer ? left_q - 12'd1 : left_q;
    tmo      = tmr_q == TW'(TIMEOUT-1);
    state_d  = cur_st;
    hcnt_d   = hcnt_q;
    hb1_d    = hb1_q;
    hb2_d    = hb2_q;
    len_d    = len_q;
    lines_d  = lines_q;
    dig_d    = dig_q;
    hv_d     = 1'b0;
    data_d   = cur_data;
    cnt_d    = cur_cnt;
    left_d   = cur_left;
    last_d   = xfer ? 1'b0 : last_q;
    err_d    = err_q;
    code_d   = code_q;
    tmr_d    = (rx_valid || (cur_st != HDR && cur_st != LOAD)) ? '0 : tmr_q + TW'(1);
    case (cur_st)
      SYNC: if (rx_valid && rx_data == 8'hAA) begin
        state_d = HDR;
        hcnt_d  = '0;
      end
      HDR: if (rx_valid) begin
        hcnt_d = hcnt_q + 2'd1;
        hb1_d  = hcnt_q == 2'd0 ? rx_data : hb1_q;
        hb2_d  = hcnt_q == 2'd1 ? rx_data : hb2_q;
        if (hcnt_q == 2'd2) begin
          if (hdr_ok) begin
            state_d = LOAD;
            len_d   = hb1_q;
            lines_d = nnn;
            dig_d   = rx_data[3:0];
            hv_d    = 1'b1;
            left_d  = nnn;
            data_d  = '0;
            cnt_d   = '0;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end
        end
      end else if (tmo) state_d = SYNC;
      LOAD: if (rx_valid) begin
        if (bad_byte) begin
          state_d = ERR;
          err_d   = 1'b1;
          code_d  = 2'd2;
          data_d  = '0;
        end else begin
          data_d = (cur_data << 8) | W'(rx_data);
          cnt_d  = cur_cnt + 8'd1;
          if (cur_cnt + 8'd1 == len_q) begin
            state_d = HOLD;
            last_d  = cur_left == 12'd1;
          end
        end
      end else if (tmo) begin
        state_d = SYNC;
        data_d  = '0;
        cnt_d   = '0;
      end
      HOLD: if (rx_valid) begin
        state_d = ERR;
        err_d   = 1'b1;
        code_d  = 2'd3;
        data_d  = '0;
        last_d  = 1'b0;
      end
      ERR: if (err_clr) begin
        state_d = SYNC;
        err_d   = 1'b0;
        code_d  = 2'd0;
      end
      default: state_d = SYNC;
    endcase
  end
  assign hdr_valid  = hv_q;
  assign hdr_len    = len_q;
  assign hdr_lines  = lines_q;
  assign hdr_digits = dig_q;
  assign line_data  = data_q;
  assign line_valid = state_q == HOLD;
  assign last_line  = last_q;
  assign err        = err_q;
  assign err_code   = code_q;
endmodule
